tft_frame_reader: RTL and testbench

Read-side counterpart of the framebuffer draw path: fetches the 480x272 RGB565 frame from SDRAM in 4-word bursts and supplies one pixel per request to the TFT scan logic. It sits between the SDRAM controller's read port and the display timing generator. A 16-word pixel FIFO decouples SDRAM read latency from the pixel request stream. The block reports underflow and frame completion.

---
 rtl/tft_frame_reader.sv | 147 ++++++++++++++
 tb/tb_tft_frame_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_frame_reader.sv
// Fetches the active frame from SDRAM in 4-word bursts into a small pixel FIFO
// and hands out one pixel per display request, flagging underflow and frame end.
module tft_frame_reader #(
  parameter int          H_ACTIVE        = 480,
  parameter int          V_ACTIVE        = 272,
  parameter logic [23:0] BASE_ADDR       = 24'h000000,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        iFrame_Start,
  output logic [23:0] oSDRAM_Rd_Addr,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  input  logic [15:0] iSDRAM_Rd_Data1,
  input  logic [15:0] iSDRAM_Rd_Data2,
  input  logic [15:0] iSDRAM_Rd_Data3,
  input  logic [15:0] iSDRAM_Rd_Data4,
  input  logic        iPixel_Req,
  output logic [15:0] oPixel_Data,
  output logic        oPixel_Valid,
  output logic        oUnderflow,
  output logic        oFrame_Done
);

  localparam int          AW           = $clog2(FIFO_DEPTH);
  localparam logic [16:0] LP_TOTAL     = 17'(H_ACTIVE * V_ACTIVE);
  localparam logic [AW:0] LP_ISSUE_MAX = (AW+1)'(FIFO_DEPTH - 4);
  localparam logic [AW:0] LP_CNT_FOUR  = (AW+1)'(4);
  localparam logic [AW:0] LP_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LP_P1      = AW'(1);
  localparam logic [AW-1:0] LP_P2      = AW'(2);
  localparam logic [AW-1:0] LP_P3      = AW'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t        r_state;
  logic [16:0]   r_fetch_idx;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [16:0]   w_fetch_next;
  logic [AW:0]   w_count_next;

  always_comb begin
    w_push  = (r_state == S_REQ) && iSDRAM_Rd_Done && !iFrame_Start;
    w_pop   = iPixel_Req && (r_count != '0) && !iFrame_Start;
    w_issue = (r_state == S_IDLE) && en && (r_fetch_idx < LP_TOTAL) &&
              (r_count <= LP_ISSUE_MAX) && !iFrame_Start;

    w_fetch_next = r_fetch_idx;
    w_count_next = r_count;
    if (iFrame_Start) begin
      w_fetch_next = '0;
      w_count_next = '0;
    end else begin
      if (w_push) w_fetch_next = r_fetch_idx + 17'd4;
      w_count_next = r_count + (w_push ? LP_CNT_FOUR : '0) - (w_pop ? LP_CNT_ONE : '0);
    end
  end

  // A request in flight cannot be aborted, so a frame restart parks in S_DRAIN
  // until its Done arrives and the stale burst is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      oSDRAM_Rd_Req  <= 1'b0;
      oSDRAM_Rd_Addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state        <= S_REQ;
            oSDRAM_Rd_Req  <= 1'b1;
            oSDRAM_Rd_Addr <= BASE_ADDR + {7'd0, r_fetch_idx};
          end
        end
        S_REQ: begin
          if (iSDRAM_Rd_Done) begin
            r_state       <= S_IDLE;
            oSDRAM_Rd_Req <= 1'b0;
          end else if (iFrame_Start) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (iSDRAM_Rd_Done) begin
            r_state       <= S_IDLE;
            oSDRAM_Rd_Req <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          oSDRAM_Rd_Req <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]         <= iSDRAM_Rd_Data1;
      r_mem[r_wr_ptr + LP_P1] <= iSDRAM_Rd_Data2;
      r_mem[r_wr_ptr + LP_P2] <= iSDRAM_Rd_Data3;
      r_mem[r_wr_ptr + LP_P3] <= iSDRAM_Rd_Data4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_idx  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      oPixel_Data  <= '0;
      oPixel_Valid <= 1'b0;
      oUnderflow   <= 1'b0;
      oFrame_Done  <= 1'b0;
    end else begin
      r_fetch_idx  <= w_fetch_next;
      r_count      <= w_count_next;
      oPixel_Valid <= iPixel_Req;
      if (iFrame_Start) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(4);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_P1;
      end
      if (iPixel_Req) oPixel_Data <= w_pop ? r_mem[r_rd_ptr] : UNDERFLOW_COLOR;
      if (iFrame_Start)
        oUnderflow <= 1'b0;
      else if (iPixel_Req && (r_count == '0))
        oUnderflow <= 1'b1;
      oFrame_Done <= !iFrame_Start && (w_fetch_next == LP_TOTAL) && (w_count_next == '0);
    end
  end

endmodule

// File: tb/tb_tft_frame_reader.sv
// Directed and randomized bench for tft_frame_reader against a queue-based
// reference of the pixel stream, burst issue rule and status flags.
module tb_tft_frame_reader;

  localparam int          H_ACT  = 40;
  localparam int          V_ACT  = 12;
  localparam int          TOTAL  = H_ACT * V_ACT;
  localparam logic [23:0] BASE   = 24'h012340;
  localparam int          FDEPTH = 16;
  localparam logic [15:0] UFCOL  = 16'hF800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        iFrame_Start = 1'b0;
  logic [23:0] oSDRAM_Rd_Addr;
  logic        oSDRAM_Rd_Req;
  logic        iSDRAM_Rd_Done = 1'b0;
  logic [15:0] iSDRAM_Rd_Data1 = '0;
  logic [15:0] iSDRAM_Rd_Data2 = '0;
  logic [15:0] iSDRAM_Rd_Data3 = '0;
  logic [15:0] iSDRAM_Rd_Data4 = '0;
  logic        iPixel_Req = 1'b0;
  logic [15:0] oPixel_Data;
  logic        oPixel_Valid;
  logic        oUnderflow;
  logic        oFrame_Done;

  tft_frame_reader #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .BASE_ADDR(BASE),
    .FIFO_DEPTH(FDEPTH), .UNDERFLOW_COLOR(UFCOL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .iFrame_Start(iFrame_Start),
    .oSDRAM_Rd_Addr(oSDRAM_Rd_Addr), .oSDRAM_Rd_Req(oSDRAM_Rd_Req),
    .iSDRAM_Rd_Done(iSDRAM_Rd_Done),
    .iSDRAM_Rd_Data1(iSDRAM_Rd_Data1), .iSDRAM_Rd_Data2(iSDRAM_Rd_Data2),
    .iSDRAM_Rd_Data3(iSDRAM_Rd_Data3), .iSDRAM_Rd_Data4(iSDRAM_Rd_Data4),
    .iPixel_Req(iPixel_Req), .oPixel_Data(oPixel_Data), .oPixel_Valid(oPixel_Valid),
    .oUnderflow(oUnderflow), .oFrame_Done(oFrame_Done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] q[$];
  bit          m_uf = 1'b0;
  int          m_fetch = 0;
  bit          discard_pending = 1'b0;
  int          lat_cnt = 0;
  bit          auto_resp = 1'b0;
  int          max_lat = 0;
  logic [15:0] pat_off = '0;
  int          n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit pix, input bit fs, input bit force_done);
    bit          done;
    bit          pre_req;
    bit          rise_exp;
    int          pre_size;
    int          pre_fetch;
    logic [23:0] pre_addr;
    logic [23:0] off;
    logic [15:0] exp_pix;
    @(negedge clk);
    pre_req  = oSDRAM_Rd_Req;
    pre_addr = oSDRAM_Rd_Addr;
    done = 1'b0;
    if (pre_req) begin
      if (force_done) done = 1'b1;
      else if (auto_resp) begin
        if (lat_cnt == 0) begin
          done = 1'b1;
          lat_cnt = $urandom_range(0, max_lat);
        end else lat_cnt--;
      end
    end
    off = oSDRAM_Rd_Addr - BASE;
    iSDRAM_Rd_Done  = done;
    iSDRAM_Rd_Data1 = off[15:0] + pat_off;
    iSDRAM_Rd_Data2 = off[15:0] + 16'd1 + pat_off;
    iSDRAM_Rd_Data3 = off[15:0] + 16'd2 + pat_off;
    iSDRAM_Rd_Data4 = off[15:0] + 16'd3 + pat_off;
    iPixel_Req   = pix;
    iFrame_Start = fs;
    pre_size  = q.size();
    pre_fetch = m_fetch;
    rise_exp  = !pre_req && en && (pre_fetch < TOTAL) && (pre_size <= FDEPTH - 4) && !fs;

    exp_pix = UFCOL;
    if (fs) begin
      q.delete();
      m_fetch = 0;
      m_uf = 1'b0;
      discard_pending = pre_req && !done;
    end else begin
      if (pix) begin
        if (q.size() > 0) exp_pix = q.pop_front();
        else m_uf = 1'b1;
      end
      if (done) begin
        n_done++;
        if (discard_pending) discard_pending = 1'b0;
        else begin
          for (int k = 0; k < 4; k++) q.push_back(16'(m_fetch + k) + pat_off);
          m_fetch += 4;
        end
      end
    end

    @(posedge clk);
    #1;
    chk("pix_valid", 32'(oPixel_Valid), 32'(pix));
    if (pix) chk("pix_data", 32'(oPixel_Data), 32'(exp_pix));
    chk("underflow", 32'(oUnderflow), 32'(m_uf));
    chk("frame_done", 32'(oFrame_Done), 32'((m_fetch == TOTAL) && (q.size() == 0)));
    chk("rd_req", 32'(oSDRAM_Rd_Req), 32'(pre_req ? !done : rise_exp));
    if (!pre_req && oSDRAM_Rd_Req)
      chk("issue_addr", 32'(oSDRAM_Rd_Addr), 32'(BASE + 24'(pre_fetch)));
    if (pre_req && oSDRAM_Rd_Req)
      chk("addr_hold", 32'(oSDRAM_Rd_Addr), 32'(pre_addr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iPixel_Req = 1'b0;
    iFrame_Start = 1'b0;
    iSDRAM_Rd_Done = 1'b0;
    q.delete();
    m_fetch = 0;
    m_uf = 1'b0;
    discard_pending = 1'b0;
    lat_cnt = 0;
    #1;
    chk("rst_req", 32'(oSDRAM_Rd_Req), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_addr", 32'(oSDRAM_Rd_Addr), 32'd0);
    chk("rst_data", 32'(oPixel_Data), 32'd0);
    chk("rst_valid", 32'(oPixel_Valid), 32'd0);
    chk("rst_uf", 32'(oUnderflow), 32'd0);
    chk("rst_done", 32'(oFrame_Done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset, first burst, second issue address, first four pixels
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    en = 1'b1;
    pat_off = 16'd1;
    step(0, 0, 0);
    chk("t1_req", 32'(oSDRAM_Rd_Req), 32'd1);
    chk("t1_addr", 32'(oSDRAM_Rd_Addr), 32'(BASE));
    step(0, 0, 1);
    chk("t1_release", 32'(oSDRAM_Rd_Req), 32'd0);
    step(0, 0, 0);
    chk("t1_addr2", 32'(oSDRAM_Rd_Addr), 32'(BASE + 24'd4));
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("t1_pix", 32'(oPixel_Data), 32'(i + 1));
    end

    // Fill with no consumer: four bursts then stall until room for a burst
    auto_resp = 1'b1;
    max_lat = 0;
    pat_off = 16'd0;
    n_done = 0;
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    chk("t2_bursts", 32'(n_done), 32'd4);
    chk("t2_req_low", 32'(oSDRAM_Rd_Req), 32'd0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk("t2_stall", 32'(oSDRAM_Rd_Req), 32'd0);
    end
    auto_resp = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("t2_req_again", 32'(oSDRAM_Rd_Req), 32'd1);

    // Reset mid-burst, then underflow on an empty FIFO
    en = 1'b0;
    do_reset();
    step(1, 0, 0);
    chk("t3_uf_data", 32'(oPixel_Data), 32'(UFCOL));
    chk("t3_uf_valid", 32'(oPixel_Valid), 32'd1);
    chk("t3_uf_flag", 32'(oUnderflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("t3_uf_sticky", 32'(oUnderflow), 32'd1);
    end
    step(1, 1, 0);
    chk("t3_fs_data", 32'(oPixel_Data), 32'(UFCOL));
    chk("t3_fs_uf", 32'(oUnderflow), 32'd0);

    // Done coinciding with a pop at count 5
    en = 1'b1;
    pat_off = 16'h1000;
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 0, 1);
    chk("t4_old_head", 32'(oPixel_Data), 32'h1003);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      chk("t4_drain", 32'(oPixel_Data), 32'(16'h1004 + 16'(i)));
    end
    step(1, 0, 0);
    chk("t4_empty", 32'(oPixel_Data), 32'(UFCOL));

    // Frame restart while a burst is outstanding
    en = 1'b1;
    pat_off = 16'd0;
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("t5_req_held", 32'(oSDRAM_Rd_Req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("t5_req_held", 32'(oSDRAM_Rd_Req), 32'd1);
    end
    pat_off = 16'hABCD;
    step(0, 0, 1);
    pat_off = 16'd0;
    step(0, 0, 0);
    chk("t5_addr", 32'(oSDRAM_Rd_Addr), 32'(BASE));
    step(0, 0, 1);
    step(1, 0, 0);
    chk("t5_first_pix", 32'(oPixel_Data), 32'd0);

    // Full frame with continuous requests
    auto_resp = 1'b1;
    max_lat = 2;
    step(0, 1, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 0);
    for (int i = 0; i < TOTAL; i++) step(1, 0, 0);
    chk("t6_frame_done", 32'(oFrame_Done), 32'd1);
    chk("t6_no_uf", 32'(oUnderflow), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("t6_no_req", 32'(oSDRAM_Rd_Req), 32'd0);

    // Random traffic with random SDRAM latency and occasional restarts
    max_lat = 5;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 299) == 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
